// File: rtl/ecc_secded_dec32.sv
// Pipelined SECDED (39,32) Hamming decoder with saturating error counters.
// Define ECC_DEC_IN_REG_EN to add an input register stage (latency 3).
module ecc_secded_dec32 #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [38:0]      code_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      data_out,
   output logic             err_corr,
   output logic             err_uncorr,
   output logic [5:0]       syndrome,
   input  logic             cnt_clr,
   output logic [CNT_W-1:0] corr_cnt,
   output logic [CNT_W-1:0] uncorr_cnt
);

   function automatic logic [31:0] extract(input logic [38:0] c);
      logic [31:0] r;
      int          j;
      r = '0;
      j = 0;
      for (int p = 1; p <= 38; p++) begin
         if ((p & (p - 1)) != 0) begin
            r[j] = c[p-1];
            j++;
         end
      end
      return r;
   endfunction

   logic en;
   assign en       = !out_valid | out_ready;
   assign in_ready = en;

   logic [38:0] cw;
   logic        cw_v;

`ifdef ECC_DEC_IN_REG_EN
   logic [38:0] c0_q;
   logic        v0_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         c0_q <= '0;
         v0_q <= 1'b0;
      end else if (en) begin
         c0_q <= code_in;
         v0_q <= in_valid;
      end
   end

   assign cw   = c0_q;
   assign cw_v = v0_q;
`else
   assign cw   = code_in;
   assign cw_v = in_valid;
`endif

   logic [5:0]  s1_d, s1_q;
   logic        g1_d, g1_q;
   logic [38:0] c1_q;
   logic        v1_q;

   always_comb begin
      logic [5:0] pos;
      s1_d = '0;
      for (int p = 1; p <= 38; p++) begin
         pos = 6'(p);
         for (int k = 0; k < 6; k++)
            if (pos[k]) s1_d[k] = s1_d[k] ^ cw[p-1];
      end
      g1_d = ^cw;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_q <= '0;
         g1_q <= 1'b0;
         c1_q <= '0;
         v1_q <= 1'b0;
      end else if (en) begin
         s1_q <= s1_d;
         g1_q <= g1_d;
         c1_q <= cw;
         v1_q <= cw_v;
      end
   end

   // Flip only on odd overall parity; s>=39 matches no position.
   logic [38:0] flip;
   logic [31:0] data_d;
   logic        corr_d, unc_d;

   always_comb begin
      flip = '0;
      for (int p = 1; p <= 38; p++)
         flip[p-1] = g1_q && (s1_q == 6'(p));
      data_d = extract(c1_q ^ flip);
      corr_d = g1_q && (s1_q <= 6'd38);
      unc_d  = (g1_q && (s1_q >= 6'd39)) || (!g1_q && (s1_q != 6'd0));
   end

   logic [31:0] data_q;
   logic        corr_q, unc_q, vld_q;
   logic [5:0]  syn_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_q <= '0;
         corr_q <= 1'b0;
         unc_q  <= 1'b0;
         syn_q  <= '0;
         vld_q  <= 1'b0;
      end else if (en) begin
         data_q <= data_d;
         corr_q <= corr_d;
         unc_q  <= unc_d;
         syn_q  <= s1_q;
         vld_q  <= v1_q;
      end
   end

   assign data_out   = data_q;
   assign err_corr   = corr_q;
   assign err_uncorr = unc_q;
   assign syndrome   = syn_q;
   assign out_valid  = vld_q;

   logic [CNT_W-1:0] ccnt_d, ccnt_q, ucnt_d, ucnt_q;
   logic             xfer;
   assign xfer = vld_q & out_ready;

   always_comb begin
      ccnt_d = ccnt_q;
      ucnt_d = ucnt_q;
      if (cnt_clr) begin
         ccnt_d = '0;
         ucnt_d = '0;
      end else if (xfer) begin
         if (corr_q && ccnt_q != '1) ccnt_d = ccnt_q + CNT_W'(1);
         if (unc_q && ucnt_q != '1)  ucnt_d = ucnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ccnt_q <= '0;
         ucnt_q <= '0;
      end else begin
         ccnt_q <= ccnt_d;
         ucnt_q <= ucnt_d;
      end
   end

   assign corr_cnt   = ccnt_q;
   assign uncorr_cnt = ucnt_q;

endmodule
